// File: rtl/adc_cbuf_writer_param_if.sv
// adc_cbuf_writer_param_if: circular-buffer RAM write port
interface adc_cbuf_writer_param_if #(
  parameter int ADDR_W = 16,
  parameter int DAT_W = 26
);
  logic circ_buf_wr_en;
  logic [ADDR_W-1:0] circ_buf_wr_addr;
  logic [DAT_W-1:0] circ_buf_wr_dat;
  modport master(output circ_buf_wr_en, circ_buf_wr_addr, circ_buf_wr_dat);
  modport slave(input circ_buf_wr_en, circ_buf_wr_addr, circ_buf_wr_dat);
endinterface

// File: rtl/adc_cbuf_writer_param.sv
// adc_cbuf_writer_param: ADC circular-buffer write engine with pre-fill, trigger capture and post window
module adc_cbuf_writer_param #(
  parameter int SAMPLE_W = 12,
  parameter int SAMPLES_PER_WORD = 2,
  parameter int ADDR_W = 16
) (
  input  logic adc_clk,
  input  logic reset_clk_adc_n,
  input  logic [SAMPLES_PER_WORD*(SAMPLE_W+1)-1:0] packed_adc_dat,
  input  logic use_dummy_data,
  input  logic dummy_dat_reset_mode,
  input  logic arm,
  input  logic trig_pulse,
  input  logic [ADDR_W-1:0] pre_trig_len,
  input  logic [ADDR_W-1:0] post_trig_len,
  adc_cbuf_writer_param_if.master buf_if,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] last_addr,
  output logic buf_wrapped,
  output logic trig_ignored,
  output logic busy,
  output logic acq_done
);
  localparam int LW = SAMPLE_W + 1;
  localparam int DW = SAMPLES_PER_WORD * LW;
  typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DONE} state_t;
  state_t state;
  logic arm_d;
  logic [ADDR_W-1:0] ptr, pre_len, post_len, cnt;
  logic [SAMPLE_W-1:0] base;
  logic [DW-1:0] ramp;
  logic [ADDR_W-1:0] post_max, post_in;
  logic arm_rise, writing, post_end, wr;
  for (genvar g = 0; g < SAMPLES_PER_WORD; g++) begin : g_ramp
    assign ramp[g*LW +: LW] = {base + SAMPLE_W'(g), 1'b0};
  end
  // pre_trig_len can never exceed DEPTH-1, so only the post window needs clamping
  assign post_max = ~pre_trig_len;
  assign post_in = post_trig_len > post_max ? post_max : post_trig_len;
  assign arm_rise = arm & ~arm_d;
  assign writing = state == FILL || state == ARMED || state == POST;
  assign post_end = state == POST && cnt == post_len;
  assign wr = (state == IDLE && arm_rise) || (writing && arm && !post_end);
  always_ff @(posedge adc_clk) begin
    if (!reset_clk_adc_n) begin
      state <= IDLE;
      arm_d <= 1'b0;
      ptr <= '0;
      pre_len <= '0;
      post_len <= '0;
      cnt <= '0;
      base <= '0;
      buf_if.circ_buf_wr_en <= 1'b0;
      buf_if.circ_buf_wr_addr <= '0;
      buf_if.circ_buf_wr_dat <= '0;
      trig_addr <= '0;
      last_addr <= '0;
      buf_wrapped <= 1'b0;
      trig_ignored <= 1'b0;
      busy <= 1'b0;
      acq_done <= 1'b0;
    end else begin
      arm_d <= arm;
      buf_if.circ_buf_wr_dat <= use_dummy_data ? ramp : packed_adc_dat;
      buf_if.circ_buf_wr_en <= wr;
      if (wr) begin
        buf_if.circ_buf_wr_addr <= ptr;
        ptr <= ptr + ADDR_W'(1);
      end
      if (wr && state != IDLE && ptr == '0) buf_wrapped <= 1'b1;
      if (wr && use_dummy_data) base <= base + SAMPLE_W'(SAMPLES_PER_WORD);
      case (state)
        IDLE: if (arm_rise) begin
          pre_len <= pre_trig_len;
          post_len <= post_in;
          trig_ignored <= 1'b0;
          buf_wrapped <= 1'b0;
          buf_if.circ_buf_wr_addr <= '0;
          ptr <= ADDR_W'(1);
          busy <= 1'b1;
          state <= pre_trig_len != '0 ? FILL : ARMED;
        end
        FILL: if (!arm) begin
          state <= IDLE;
          busy <= 1'b0;
        end else begin
          if (trig_pulse) trig_ignored <= 1'b1;
          if (ptr == pre_len) state <= ARMED;
        end
        ARMED: if (!arm) begin
          state <= IDLE;
          busy <= 1'b0;
        end else if (trig_pulse) begin
          trig_addr <= ptr;
          cnt <= '0;
          state <= POST;
          if (dummy_dat_reset_mode) base <= '0;
        end
        POST: if (!arm) begin
          state <= IDLE;
          busy <= 1'b0;
        end else if (post_end) begin
          last_addr <= buf_if.circ_buf_wr_addr;
          busy <= 1'b0;
          acq_done <= 1'b1;
          state <= DONE;
        end else cnt <= cnt + ADDR_W'(1);
        DONE: if (!arm) begin
          acq_done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_cbuf_writer_param.sv
// tb_adc_cbuf_writer_param: randomized bench against an acquisition-level word-count model
module tb_adc_cbuf_writer_param;
  localparam int SW = 5, SPW = 3, AW = 5, LW = SW + 1, DW = SPW * LW, DEPTH = 1 << AW;
  logic clk = 1'b0, rstn = 1'b0;
  logic [DW-1:0] pk = '0;
  logic dum = 1'b0, drm = 1'b0, arm = 1'b0, trig = 1'b0;
  logic [AW-1:0] pre = '0, post = '0;
  logic [AW-1:0] trig_addr, last_addr;
  logic wrapped, ignored, busy, done;
  int n_chk = 0, n_fail = 0;
  adc_cbuf_writer_param_if #(.ADDR_W(AW), .DAT_W(DW)) bi();
  adc_cbuf_writer_param #(.SAMPLE_W(SW), .SAMPLES_PER_WORD(SPW), .ADDR_W(AW)) dut (
    .adc_clk(clk), .reset_clk_adc_n(rstn), .packed_adc_dat(pk), .use_dummy_data(dum),
    .dummy_dat_reset_mode(drm), .arm(arm), .trig_pulse(trig), .pre_trig_len(pre),
    .post_trig_len(post), .buf_if(bi.master), .trig_addr(trig_addr), .last_addr(last_addr),
    .buf_wrapped(wrapped), .trig_ignored(ignored), .busy(busy), .acq_done(done)
  );
  always #5 clk = ~clk;
  // model: acquisition tracked by words written (n) and index of trigger word (trig_n)
  int n, trig_n, m_pre, m_post, mbase;
  bit active, donef, marm_d;
  bit e_en, e_wrap, e_ign;
  int e_addr, e_taddr, e_laddr;
  logic [DW-1:0] e_dat;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] ramp(input int b);
    logic [DW-1:0] r = '0;
    for (int k = 0; k < SPW; k++) r[k*LW+1 +: SW] = SW'((b + k) % (1 << SW));
    return r;
  endfunction
  task automatic step();
    bit wr = 0, clr = 0, rise;
    if (!rstn) begin
      n = 0; trig_n = -1; m_pre = 0; m_post = 0; mbase = 0;
      active = 0; donef = 0; marm_d = 0;
      e_en = 0; e_wrap = 0; e_ign = 0; e_addr = 0; e_taddr = 0; e_laddr = 0; e_dat = '0;
      return;
    end
    rise = arm && !marm_d;
    e_dat = dum ? ramp(mbase) : pk;
    if (donef) begin
      if (!arm) donef = 0;
    end else if (!active) begin
      if (rise) begin
        m_pre = int'(pre);
        m_post = (int'(post) < DEPTH - 1 - m_pre) ? int'(post) : DEPTH - 1 - m_pre;
        n = 0; trig_n = -1; e_ign = 0; e_wrap = 0; active = 1; wr = 1;
      end
    end else if (!arm) active = 0;
    else if (trig_n < 0) begin
      if (n <= m_pre) begin
        if (trig) e_ign = 1;
      end else if (trig) begin
        trig_n = n; e_taddr = n % DEPTH; clr = drm;
      end
      wr = 1;
    end else if (n - 1 - trig_n == m_post) begin
      active = 0; donef = 1; e_laddr = (n - 1) % DEPTH;
    end else wr = 1;
    if (wr) begin
      e_addr = n % DEPTH;
      if (n > 0 && n % DEPTH == 0) e_wrap = 1;
      n++;
    end
    e_en = wr;
    if (wr && dum) mbase = (mbase + SPW) % (1 << SW);
    if (clr) mbase = 0;
    marm_d = arm;
  endtask
  function automatic logic [AW-1:0] pick_len();
    int r = $urandom_range(0, 9);
    return r == 0 ? AW'(0) : r == 1 ? AW'(DEPTH - 1) : r == 2 ? AW'($urandom) : AW'($urandom_range(1, 6));
  endfunction
  initial begin
    int tdiv = 10;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (c % 250 == 0) tdiv = c % 750 == 0 ? 3 : c % 500 == 0 ? 15 : 60;
      rstn = c < 3 ? 1'b0 : ($urandom_range(0, 599) != 0);
      arm = arm ? ($urandom_range(0, donef ? 3 : 99) != 0) : ($urandom_range(0, 2) == 0);
      trig = $urandom_range(0, tdiv - 1) == 0;
      pre = pick_len();
      post = pick_len();
      dum = c % 400 < 250;
      drm = 1'($urandom_range(0, 1));
      pk = DW'($urandom);
      @(posedge clk);
      step();
      #1;
      check("wr_en", 32'(bi.circ_buf_wr_en), 32'(e_en));
      check("wr_addr", 32'(bi.circ_buf_wr_addr), 32'(e_addr));
      check("wr_dat", 32'(bi.circ_buf_wr_dat), 32'(e_dat));
      check("trig_addr", 32'(trig_addr), 32'(e_taddr));
      check("last_addr", 32'(last_addr), 32'(e_laddr));
      check("buf_wrapped", 32'(wrapped), 32'(e_wrap));
      check("trig_ignored", 32'(ignored), 32'(e_ign));
      check("busy", 32'(busy), 32'(active));
      check("acq_done", 32'(done), 32'(donef));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
